spi_io_expander: RTL and testbench

- SPI-slave output expander for an 8-in/8-out pin-wrapper tile.
- A serial frame on ss/sclk/mosi updates an 8-bit output register that drives io_out[7:0] directly.
- All logic runs in the single system clock domain (io_in[4]). SPI pins are asynchronous and are synchronised internally.

---
 rtl/spi_io_expander.sv | 117 +++++++++++
 tb/tb_spi_io_expander.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_io_expander.sv
// SPI-slave 8-bit output expander: mode-0 frames of {cmd, data} update io_out.
// Define SPI_IO_EXPANDER_BITOPS_EN to add the SET/CLEAR/TOGGLE commands.
module spi_io_expander #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] RESET_VALUE = 8'h00
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    logic clk;
    logic rst;
    logic ss_pin;
    logic sclk_pin;
    logic mosi_pin;
    logic unused_pins;

    assign clk         = io_in[4];
    assign rst         = io_in[5];
    assign ss_pin      = io_in[0];
    assign sclk_pin    = io_in[1];
    assign mosi_pin    = io_in[3];
    assign unused_pins = ^{io_in[7:6], io_in[2]};

    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   ss_prev;
    logic                   sclk_prev;
    logic [SYNC_STAGES:0]   settle;

    logic [15:0] shift_reg;
    logic [4:0]  bit_cnt;
    logic        active;

    logic       ss_s;
    logic       sclk_s;
    logic       mosi_s;
    logic       ss_fall;
    logic       ss_rise;
    logic       sclk_rise;
    logic       commit;
    logic [7:0] cmd;
    logic [7:0] data;
    logic [7:0] next_out;

    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // A falling ss only counts once ss_prev holds a pin-derived level,
    // so ss already low at reset release does not start a frame.
    assign ss_fall   = settle[SYNC_STAGES] & ss_prev & ~ss_s;
    assign ss_rise   = ~ss_prev & ss_s;
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign commit    = ss_rise & active & (bit_cnt == 5'd16);

    assign cmd  = shift_reg[15:8];
    assign data = shift_reg[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            ss_sync   <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_prev   <= 1'b1;
            sclk_prev <= 1'b0;
            settle    <= '0;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_pin};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_pin};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_pin};
            ss_prev   <= ss_s;
            sclk_prev <= sclk_s;
            settle    <= {settle[SYNC_STAGES-1:0], 1'b1};
        end
    end

    always_comb begin
        next_out = io_out;
        case (cmd)
            8'h01: next_out = data;
`ifdef SPI_IO_EXPANDER_BITOPS_EN
            8'h02: next_out = io_out | data;
            8'h03: next_out = io_out & ~data;
            8'h04: next_out = io_out ^ data;
`endif
            default: next_out = io_out;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            active    <= 1'b0;
            io_out    <= RESET_VALUE;
        end else begin
            if (ss_fall) begin
                shift_reg <= '0;
                bit_cnt   <= '0;
                active    <= 1'b1;
            end else if (ss_rise) begin
                active <= 1'b0;
            end else if (active && !ss_s && sclk_rise) begin
                shift_reg <= {shift_reg[14:0], mosi_s};
                if (bit_cnt != 5'd17) begin
                    bit_cnt <= bit_cnt + 5'd1;
                end
            end
            if (commit) begin
                io_out <= next_out;
            end
        end
    end

endmodule

// File: tb/tb_spi_io_expander.sv
// Scoreboard bench for spi_io_expander: SPI frames at clk/8, expected
// io_out values queued at frame end and compared after the sync latency.
module tb_spi_io_expander;

    localparam int SYNC = 2;

    logic       clk;
    logic       rst;
    logic       ss;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic [1:0] spare;
    logic [7:0] io_in;
    logic [7:0] io_out;
    bit         noisy;

    logic [7:0] model;
    logic [7:0] sb_q[$];
    int         vectors;
    int         miscompares;

    assign io_in = {spare, rst, clk, mosi, miso, sclk, ss};

    spi_io_expander #(
        .SYNC_STAGES(SYNC),
        .RESET_VALUE(8'h00)
    ) dut (
        .io_in (io_in),
        .io_out(io_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: io_out=%02h expected=%02h", tag, got, exp);
        end
    endtask

    task automatic stir();
        if (noisy) begin
            miso  = 1'($urandom_range(0, 1));
            spare = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = bits[i];
            stir();
            wait_clk(4);
            sclk = 1'b1;
            stir();
            wait_clk(4);
            sclk = 1'b0;
        end
    endtask

    function automatic logic [7:0] apply(input logic [7:0] cur,
                                         input logic [7:0] c,
                                         input logic [7:0] d);
        logic [7:0] r;
        r = cur;
        if (c == 8'h01) r = d;
`ifdef SPI_IO_EXPANDER_BITOPS_EN
        if (c == 8'h02) r = cur | d;
        if (c == 8'h03) r = cur & ~d;
        if (c == 8'h04) r = cur ^ d;
`endif
        return r;
    endfunction

    // Drives one frame and pushes the value io_out must then show.
    task automatic frame(input logic [31:0] bits, input int n);
        wait_clk(1);
        ss = 1'b0;
        wait_clk(4);
        shift_bits(bits, n);
        wait_clk(4);
        ss = 1'b1;
        if (n == 16) model = apply(model, bits[15:8], bits[7:0]);
        sb_q.push_back(model);
    endtask

    task automatic expect_out(input string tag);
        logic [7:0] exp;
        repeat (SYNC + 2) @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            exp = sb_q.pop_front();
            check(tag, io_out, exp);
        end
        wait_clk(3);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        wait_clk(n);
        rst = 1'b0;
        model = 8'h00;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        noisy       = 1'b0;
        rst   = 1'b1;
        ss    = 1'b1;
        sclk  = 1'b0;
        mosi  = 1'b0;
        miso  = 1'b0;
        spare = 2'b00;
        model = 8'h00;

        wait_clk(2);
        check("reset", io_out, 8'h00);
        for (int i = 0; i < 8; i++) begin
            sclk = ~sclk;
            mosi = ~mosi;
            wait_clk(1);
        end
        check("reset_hold", io_out, 8'h00);
        sclk = 1'b0;
        mosi = 1'b0;
        rst  = 1'b0;
        wait_clk(6);

        frame(32'h01A5, 16);
        expect_out("write_a5");
        frame(32'h020F, 16);
        expect_out("set_0f");
        frame(32'h0381, 16);
        expect_out("clear_81");
        frame(32'h04FF, 16);
        expect_out("toggle_ff");

        frame(32'h013C, 16);
        expect_out("write_3c");
        frame(32'h0155 >> 1, 15);
        expect_out("short_15");
        frame({15'h0, 17'h0155}, 17);
        expect_out("long_17");
        frame(32'h7E00, 16);
        expect_out("unknown_7e");

        wait_clk(1);
        ss = 1'b0;
        wait_clk(4);
        shift_bits(32'h0155 >> 7, 9);
        do_reset(2);
        wait_clk(2);
        check("abort_rst", io_out, 8'h00);
        shift_bits(32'h0111, 16);
        wait_clk(4);
        ss = 1'b1;
        sb_q.push_back(model);
        expect_out("stale_ss_low");
        frame(32'h0199, 16);
        expect_out("write_99");

        noisy = 1'b1;
        frame(32'h0166, 16);
        expect_out("noise_66");
        noisy = 1'b0;
        miso  = 1'b0;
        spare = 2'b00;

        mosi = 1'b1;
        shift_bits(32'hFFFF, 16);
        sb_q.push_back(model);
        expect_out("sclk_ss_high");

        frame(32'h0, 0);
        expect_out("ss_pulse");

        wait_clk(1);
        ss = 1'b0;
        wait_clk(4);
        shift_bits(32'h0111, 16);
        wait_clk(4);
        ss = 1'b1;
        model = apply(model, 8'h01, 8'h11);
        wait_clk(2);
        frame(32'h0433, 16);
        expect_out("back_to_back");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation bound expired");
        $fatal(1);
    end

endmodule
